i2c_target_regs: RTL



---
 rtl/i2c_tgt_pkg.sv | 18 +
 rtl/i2c_in_filter.sv | 50 +++++
 rtl/i2c_target_regs.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/i2c_tgt_pkg.sv
// Shared types and widths for the I2C register-bank target.
// No logic of its own; imported by the filter and the target.
package i2c_tgt_pkg;
   localparam int DEV_ADDR_W = 7;
   localparam int BYTE_W     = 8;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ACK_A,
      ST_PTR,
      ST_ACK_P,
      ST_WR,
      ST_ACK_W,
      ST_RD,
      ST_MACK
   } state_t;
endpackage

// File: rtl/i2c_in_filter.sv
// Two-flop synchroniser plus run-length glitch filter for one I2C line; edges are 1-clk pulses.
// Latency: 2 + FILTER_LEN clk from pin to level/edge; no backpressure (free-running).
module i2c_in_filter
   import i2c_tgt_pkg::*;
#(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic pin_i,
   output logic lvl_o,
   output logic rise_o,
   output logic fall_o
);
   localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

   logic          s1_q, s2_q, lvl_q, rise_q, fall_q;
   logic [CW-1:0] cnt_q;

   // A new level is accepted only after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q   <= 1'b1;
         s2_q   <= 1'b1;
         lvl_q  <= 1'b1;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         s1_q   <= pin_i;
         s2_q   <= s1_q;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         if (s2_q == lvl_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
            lvl_q  <= s2_q;
            rise_q <= s2_q;
            fall_q <= ~s2_q;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign lvl_o  = lvl_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;
endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte register bank with shared auto-increment pointer and write strobe.
// Latency: SCL fall to SDA change FILTER_LEN+3 clk; no clock stretching, so clk must fit this in tLOW.
module i2c_target_regs
   import i2c_tgt_pkg::*;
#(
   parameter logic [DEV_ADDR_W-1:0] DEV_ADDR   = 7'h50,
   parameter int                    NUM_REGS   = 16,
   parameter int                    FILTER_LEN = 3,
   localparam int                   AW = ($clog2(NUM_REGS) < 2) ? 2 : $clog2(NUM_REGS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i2c_scl_i,
   output logic                       i2c_scl_o,
   output logic                       i2c_scl_t,
   input  logic                       i2c_sda_i,
   output logic                       i2c_sda_o,
   output logic                       i2c_sda_t,
   output logic [NUM_REGS*BYTE_W-1:0] regs_q,
   output logic                       wr_stb,
   output logic [AW-1:0]              wr_addr,
   output logic                       busy
);
   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
      .clk    (clk),
      .rst    (rst),
      .pin_i  (i2c_scl_i),
      .lvl_o  (scl_lvl),
      .rise_o (scl_rise),
      .fall_o (scl_fall)
   );

   i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
      .clk    (clk),
      .rst    (rst),
      .pin_i  (i2c_sda_i),
      .lvl_o  (sda_lvl),
      .rise_o (sda_rise),
      .fall_o (sda_fall)
   );

   state_t              state_q;
   logic [BYTE_W-1:0]   sr_q;
   logic [2:0]          cnt_q;
   logic [AW-1:0]       ptr_q;
   logic                sda_t_q, wr_stb_q, busy_q;
   logic [AW-1:0]       wr_addr_q;

   logic                start_det, stop_det, ptr_ok;
   logic [AW-1:0]       ptr_inc_d;
   logic [BYTE_W-1:0]   byte_in_d;

   assign start_det = sda_fall & scl_lvl;
   assign stop_det  = sda_rise & scl_lvl;
   assign byte_in_d = {sr_q[BYTE_W-2:0], sda_lvl};
   assign ptr_inc_d = (ptr_q == AW'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;
   assign ptr_ok    = ({1'b0, ptr_q} < (AW + 1)'(NUM_REGS));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         sr_q      <= '0;
         cnt_q     <= '0;
         ptr_q     <= '0;
         sda_t_q   <= 1'b1;
         wr_stb_q  <= 1'b0;
         wr_addr_q <= '0;
         busy_q    <= 1'b0;
         regs_q    <= '0;
      end else begin
         wr_stb_q <= 1'b0;
         if (start_det) begin
            state_q <= ST_ADDR;
            cnt_q   <= '0;
            sda_t_q <= 1'b1;
            busy_q  <= 1'b1;
         end else if (stop_det) begin
            state_q <= ST_IDLE;
            sda_t_q <= 1'b1;
            busy_q  <= 1'b0;
         end else if (scl_fall) begin
            // SDA only ever changes while SCL is low.
            case (state_q)
               ST_ACK_A, ST_ACK_P, ST_ACK_W: sda_t_q <= 1'b0;
               ST_RD: begin
                  sda_t_q <= sr_q[BYTE_W-1];
                  sr_q    <= {sr_q[BYTE_W-2:0], 1'b0};
               end
               default: sda_t_q <= 1'b1;
            endcase
         end else if (scl_rise) begin
            case (state_q)
               ST_ADDR, ST_PTR, ST_WR: begin
                  sr_q  <= byte_in_d;
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == 3'd7) begin
                     case (state_q)
                        ST_ADDR: state_q <= (byte_in_d[BYTE_W-1:1] == DEV_ADDR) ? ST_ACK_A : ST_IDLE;
                        ST_PTR: begin
                           ptr_q   <= byte_in_d[AW-1:0];
                           state_q <= ST_ACK_P;
                        end
                        default: state_q <= ST_ACK_W;
                     endcase
                  end
               end
               ST_ACK_A: begin
                  cnt_q <= '0;
                  if (sr_q[0]) begin
                     sr_q    <= regs_q[int'(ptr_q)*BYTE_W +: BYTE_W];
                     state_q <= ST_RD;
                  end else begin
                     state_q <= ST_PTR;
                  end
               end
               ST_ACK_P: begin
                  cnt_q   <= '0;
                  state_q <= ST_WR;
               end
               ST_ACK_W: begin
                  cnt_q   <= '0;
                  state_q <= ST_WR;
                  ptr_q   <= ptr_inc_d;
                  if (ptr_ok) begin
                     regs_q[int'(ptr_q)*BYTE_W +: BYTE_W] <= sr_q;
                     wr_stb_q  <= 1'b1;
                     wr_addr_q <= ptr_q;
                  end
               end
               ST_RD: begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == 3'd7) state_q <= ST_MACK;
               end
               ST_MACK: begin
                  if (!sda_lvl) begin
                     ptr_q   <= ptr_inc_d;
                     sr_q    <= regs_q[int'(ptr_inc_d)*BYTE_W +: BYTE_W];
                     cnt_q   <= '0;
                     state_q <= ST_RD;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Reset must let go of SDA immediately, not one edge later.
   assign i2c_sda_t = sda_t_q | rst;
   assign i2c_sda_o = 1'b0;
   assign i2c_scl_o = 1'b0;
   assign i2c_scl_t = 1'b1;
   assign wr_stb    = wr_stb_q;
   assign wr_addr   = wr_addr_q;
   assign busy      = busy_q;
endmodule
